id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the five-stage pipeline CPU; captures decoded operands and control from ID each cycle.
- Drives the ALU operand pair and aluop with EX/MEM and MEM/WB forwarding applied.
- Detects load-use hazards, raises the ID/IF hold request, and inserts a bubble into EX.

Parameters:
- DW, 32, datapath width (operands, pc, immediate)
- RW, 5, register-index width
- BUBBLE_OP, 13, aluop value written on a bubble (ALU outputs 0)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DW  instruction PC
- id_rs_data, id_rt_data  in  DW each  register-file read data
- id_imm  in  DW  extended immediate
- id_rs, id_rt, id_rd  in  RW each  source and destination indices (id_rd already resolved rt/rd)
- id_aluop  in  4  ALU operation code
- id_alusrc  in  1  1 = operand B from immediate
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  control bits
- flush  in  1  branch/jump squash of the ID instruction
- exmem_regwrite  in  1  EX/MEM writes the register file
- exmem_rd  in  RW  EX/MEM destination register
- exmem_result  in  DW  EX/MEM ALU result
- memwb_regwrite  in  1  MEM/WB writes the register file
- memwb_rd  in  RW  MEM/WB destination register
- memwb_wdata  in  DW  MEM/WB write-back data
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  registered control bits
- ex_pc  out  DW  registered PC
- ex_rd  out  RW  registered destination register
- ex_aluop  out  4  to ALU aluop
- alu_a, alu_b  out  DW each  to ALU a and b (combinational from registers plus forward inputs)
- ex_store_data  out  DW  forwarded rt value for stores
- hold_id  out  1  combinational load-use stall request to IF/ID

Behaviour:
Reset and priority:
- Priority at each clk edge: rst > flush > load-use bubble > normal load.
- Reset and bubble values: all control outputs 0, ex_aluop = BUBBLE_OP, ex_pc/ex_rd/stored data/immediate/indices = 0.
- On a bubble, alu_a and alu_b are don't-care but must be deterministic (forwarding logic still applies).

Load-use hazard and loading:
- hold_id = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs) | (ex_rd == id_rt)).
- hold_id is asserted regardless of flush. When hold_id=1 and flush=0, the next state is a bubble; IF/ID holds its contents externally.
- If flush=1, a bubble is loaded whatever the other inputs are.
- If id_valid=0, a bubble is loaded.
- Otherwise, on a normal load, all id_* fields are latched; ex_valid=1.
- Latency: one cycle from ID inputs to ex_* outputs. hold_id adds exactly one bubble cycle per load-use pair.

Forwarding (per operand; applies to stored rs and rt separately):
- Priority 1, EX/MEM: if exmem_regwrite, exmem_rd != 0 and exmem_rd == stored index, use exmem_result.
- Priority 2, MEM/WB: else if memwb_regwrite, memwb_rd != 0 and memwb_rd == stored index, use memwb_wdata.
- Otherwise use the latched register data.
- Register 0 is never forwarded; its value is the latched data, which is 0 from the register file.

Operand outputs:
- alu_a = forwarded rs.
- alu_b = ex_alusrc ? latched imm : forwarded rt.
- ex_store_data = forwarded rt, always, regardless of alusrc.
- Operands and aluop pass unmodified; signed/unsigned interpretation is the ALU's job.

Boundary conditions:
- Back-to-back identical destination registers: EX/MEM wins.
- A flush coinciding with a load-use hazard yields one bubble, not two.
- Reset asserted mid-stream clears within the same edge; hold_id is 0 the cycle after reset because ex_valid=0.

Test Plan:
- Reset: rst=1 for 2 cycles with random ID inputs -> ex_valid=0, ex_aluop=13, all control bits 0, hold_id=0.
- Normal load: id_valid=1, aluop=0, rs_data=5, imm=7, alusrc=1, no forwarding -> next cycle alu_a=5, alu_b=7, ex_valid=1.
- EX/MEM vs MEM/WB priority: stored rs=rt=8, exmem_rd=8 with result 0x11, memwb_rd=8 with data 0x22, both regwrite=1 -> alu_a=0x11 and ex_store_data=0x11. Then drop exmem_regwrite -> both become 0x22.
- $0 guard: stored rs=0, exmem_rd=0, exmem_regwrite=1, result 0xFFFF -> alu_a equals latched data 0.
- Load-use: EX holds lw with rd=9; ID sends add with rs=9 -> hold_id=1 that cycle. Next edge loads a bubble (aluop 13, regwrite 0). Reloading the same add then proceeds, hold_id=0.
- Flush plus hazard: load-use condition with flush=1 -> exactly one bubble. A subsequent valid instruction loads normally the following cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage pipeline.
// Latches decoded operands and control from ID, applies EX/MEM and MEM/WB
// forwarding to the ALU operands and store data, and detects load-use
// hazards. A hazard raises the ID stall request and puts a bubble into EX.
module id_ex_stage #(
    parameter int         DW        = 32,
    parameter int         RW        = 5,
    parameter logic [3:0] BUBBLE_OP = 4'd13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [3:0]    id_aluop,
    input  logic          id_alusrc,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          flush,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_wdata,
    output logic          ex_valid,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic [DW-1:0] ex_pc,
    output logic [RW-1:0] ex_rd,
    output logic [3:0]    ex_aluop,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [DW-1:0] ex_store_data,
    output logic          hold_id
);

    localparam logic [RW-1:0] REG_ZERO = {RW{1'b0}};
    localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

    // Pipeline state
    logic          ex_valid_r;
    logic          ex_regwrite_r;
    logic          ex_memread_r;
    logic          ex_memwrite_r;
    logic          ex_memtoreg_r;
    logic          ex_alusrc_r;
    logic [DW-1:0] ex_pc_r;
    logic [RW-1:0] ex_rd_r;
    logic [RW-1:0] ex_rs_r;
    logic [RW-1:0] ex_rt_r;
    logic [DW-1:0] ex_rs_data_r;
    logic [DW-1:0] ex_rt_data_r;
    logic [DW-1:0] ex_imm_r;
    logic [3:0]    ex_aluop_r;

    // Combinational helpers
    logic          hold_s;
    logic          load_bubble_s;
    logic [DW-1:0] fwd_rs_s;
    logic [DW-1:0] fwd_rt_s;
    logic [DW-1:0] alu_b_s;

    // Forwarding mux for one stored operand. The younger EX/MEM producer
    // wins over MEM/WB; register 0 is never forwarded so it keeps the
    // register-file value of zero.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] idx,
        input logic [DW-1:0] latched,
        input logic          em_wr,
        input logic [RW-1:0] em_rd,
        input logic [DW-1:0] em_data,
        input logic          mw_wr,
        input logic [RW-1:0] mw_rd,
        input logic [DW-1:0] mw_data
    );
        logic [DW-1:0] res;
        if (em_wr && (em_rd != REG_ZERO) && (em_rd == idx)) begin
            res = em_data;
        end else if (mw_wr && (mw_rd != REG_ZERO) && (mw_rd == idx)) begin
            res = mw_data;
        end else begin
            res = latched;
        end
        return res;
    endfunction

    // Load-use detection: a load in EX whose destination is read by the ID instruction
    always_comb begin
        hold_s = ex_valid_r && ex_memread_r && (ex_rd_r != REG_ZERO) && id_valid
                 && ((ex_rd_r == id_rs) || (ex_rd_r == id_rt));
        load_bubble_s = flush || hold_s || !id_valid;
    end

    // Pipeline register: reset and bubble share the same cleared image
    always_ff @(posedge clk) begin
        if (rst || load_bubble_s) begin
            ex_valid_r    <= 1'b0;
            ex_regwrite_r <= 1'b0;
            ex_memread_r  <= 1'b0;
            ex_memwrite_r <= 1'b0;
            ex_memtoreg_r <= 1'b0;
            ex_alusrc_r   <= 1'b0;
            ex_pc_r       <= DATA_ZERO;
            ex_rd_r       <= REG_ZERO;
            ex_rs_r       <= REG_ZERO;
            ex_rt_r       <= REG_ZERO;
            ex_rs_data_r  <= DATA_ZERO;
            ex_rt_data_r  <= DATA_ZERO;
            ex_imm_r      <= DATA_ZERO;
            ex_aluop_r    <= BUBBLE_OP;
        end else begin
            ex_valid_r    <= 1'b1;
            ex_regwrite_r <= id_regwrite;
            ex_memread_r  <= id_memread;
            ex_memwrite_r <= id_memwrite;
            ex_memtoreg_r <= id_memtoreg;
            ex_alusrc_r   <= id_alusrc;
            ex_pc_r       <= id_pc;
            ex_rd_r       <= id_rd;
            ex_rs_r       <= id_rs;
            ex_rt_r       <= id_rt;
            ex_rs_data_r  <= id_rs_data;
            ex_rt_data_r  <= id_rt_data;
            ex_imm_r      <= id_imm;
            ex_aluop_r    <= id_aluop;
        end
    end

    // Operand forwarding and operand-B selection
    always_comb begin
        fwd_rs_s = fwd_sel(ex_rs_r, ex_rs_data_r, exmem_regwrite, exmem_rd, exmem_result,
                           memwb_regwrite, memwb_rd, memwb_wdata);
        fwd_rt_s = fwd_sel(ex_rt_r, ex_rt_data_r, exmem_regwrite, exmem_rd, exmem_result,
                           memwb_regwrite, memwb_rd, memwb_wdata);
        if (ex_alusrc_r) begin
            alu_b_s = ex_imm_r;
        end else begin
            alu_b_s = fwd_rt_s;
        end
    end

    assign ex_valid      = ex_valid_r;
    assign ex_regwrite   = ex_regwrite_r;
    assign ex_memread    = ex_memread_r;
    assign ex_memwrite   = ex_memwrite_r;
    assign ex_memtoreg   = ex_memtoreg_r;
    assign ex_pc         = ex_pc_r;
    assign ex_rd         = ex_rd_r;
    assign ex_aluop      = ex_aluop_r;
    assign alu_a         = fwd_rs_s;
    assign alu_b         = alu_b_s;
    assign ex_store_data = fwd_rt_s;
    assign hold_id       = hold_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for single-cycle loads and
// forwarding, plus hand sequences for reset, load-use, flush and mid-stream reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [3:0]  id_aluop;
    logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        flush;
    logic        exmem_regwrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_wdata;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_aluop;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic        hold_id;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluop(id_aluop),
        .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .flush(flush),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_pc(ex_pc),
        .ex_rd(ex_rd), .ex_aluop(ex_aluop), .alu_a(alu_a), .alu_b(alu_b),
        .ex_store_data(ex_store_data), .hold_id(hold_id)
    );

    // ctl   = {regwrite, memread, memwrite, memtoreg}
    // e_ctl = {valid, regwrite, memread, memwrite, memtoreg}
    typedef struct {
        logic        valid;
        logic [31:0] pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic [3:0]  aluop;
        logic        alusrc;
        logic [3:0]  ctl;
        logic        flush;
        logic        exwr;
        logic [4:0]  exrd;
        logic [31:0] exres;
        logic        mwwr;
        logic [4:0]  mwrd;
        logic [31:0] mwdata;
        logic        e_hold;
        logic [4:0]  e_ctl;
        logic [3:0]  e_aluop;
        logic [4:0]  e_rd;
        logic [31:0] e_pc, e_a, e_b, e_st;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [3:0] op, input logic src, input logic [3:0] ctl,
                          input logic fl);
        id_valid = v; id_pc = pc; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_aluop = op; id_alusrc = src;
        {id_regwrite, id_memread, id_memwrite, id_memtoreg} = ctl;
        flush = fl;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                           input logic mw, input logic [4:0] mr, input logic [31:0] md);
        exmem_regwrite = ew; exmem_rd = er; exmem_result = ed;
        memwb_regwrite = mw; memwb_rd = mr; memwb_wdata = md;
    endtask

    task automatic chk_bubble(input string name);
        chk({name, ".valid"}, {31'd0, ex_valid}, 32'd0);
        chk({name, ".aluop"}, {28'd0, ex_aluop}, 32'd13);
        chk({name, ".ctl"}, {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}, 32'd0);
        chk({name, ".pc"}, ex_pc, 32'd0);
        chk({name, ".rd"}, {27'd0, ex_rd}, 32'd0);
    endtask

    initial begin
        //        valid pc       rs_data    rt_data    imm        rs    rt    rd     op    src  ctl      fl    exwr exrd  exres        mwwr mwrd  mwdata       hold  e_ctl      e_op  e_rd   e_pc      e_a        e_b       e_st
        vecs[0] = '{1'b1, 32'h100, 32'd5,     32'd6,     32'd7,     5'd1, 5'd2, 5'd3,  4'd0, 1'b1, 4'b1000, 1'b0, 1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,       1'b0, 5'b11000, 4'd0, 5'd3,  32'h100, 32'd5,     32'd7,    32'd6};
        vecs[1] = '{1'b1, 32'h104, 32'h10,    32'h20,    32'h99,    5'd4, 5'd5, 5'd6,  4'd2, 1'b0, 4'b1000, 1'b0, 1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,       1'b0, 5'b11000, 4'd2, 5'd6,  32'h104, 32'h10,    32'h20,   32'h20};
        vecs[2] = '{1'b1, 32'h108, 32'd1,     32'd2,     32'd3,     5'd8, 5'd8, 5'd10, 4'd1, 1'b0, 4'b1000, 1'b0, 1'b1, 5'd8, 32'h11,     1'b1, 5'd8, 32'h22,      1'b0, 5'b11000, 4'd1, 5'd10, 32'h108, 32'h11,    32'h11,   32'h11};
        vecs[3] = '{1'b1, 32'h10c, 32'd1,     32'd2,     32'd3,     5'd8, 5'd8, 5'd10, 4'd1, 1'b0, 4'b1000, 1'b0, 1'b0, 5'd8, 32'h11,     1'b1, 5'd8, 32'h22,      1'b0, 5'b11000, 4'd1, 5'd10, 32'h10c, 32'h22,    32'h22,   32'h22};
        vecs[4] = '{1'b1, 32'h110, 32'd1,     32'd2,     32'h55,    5'd8, 5'd9, 5'd11, 4'd4, 1'b1, 4'b1000, 1'b0, 1'b1, 5'd8, 32'h44,     1'b1, 5'd9, 32'h33,      1'b0, 5'b11000, 4'd4, 5'd11, 32'h110, 32'h44,    32'h55,   32'h33};
        vecs[5] = '{1'b1, 32'h114, 32'd0,     32'd0,     32'd7,     5'd0, 5'd0, 5'd12, 4'd5, 1'b0, 4'b1000, 1'b0, 1'b1, 5'd0, 32'hFFFF,   1'b1, 5'd0, 32'hABCD,    1'b0, 5'b11000, 4'd5, 5'd12, 32'h114, 32'd0,     32'd0,    32'd0};
        vecs[6] = '{1'b0, 32'h118, 32'd3,     32'd4,     32'd9,     5'd1, 5'd2, 5'd13, 4'd6, 1'b1, 4'b1111, 1'b0, 1'b1, 5'd0, 32'd5,      1'b0, 5'd0, 32'd0,       1'b0, 5'b00000, 4'd13, 5'd0, 32'd0,    32'd0,     32'd0,    32'd0};
        vecs[7] = '{1'b1, 32'h11c, 32'd3,     32'd4,     32'd9,     5'd1, 5'd2, 5'd14, 4'd7, 1'b1, 4'b1110, 1'b1, 1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,       1'b0, 5'b00000, 4'd13, 5'd0, 32'd0,    32'd0,     32'd0,    32'd0};
        vecs[8] = '{1'b1, 32'h120, 32'h1000,  32'hDEAD,  32'd8,     5'd2, 5'd3, 5'd0,  4'd0, 1'b1, 4'b0010, 1'b0, 1'b0, 5'd0, 32'd0,      1'b1, 5'd3, 32'hBEEF,    1'b0, 5'b10010, 4'd0, 5'd0,  32'h120, 32'h1000,  32'd8,    32'hBEEF};
        vecs[9] = '{1'b1, 32'h124, 32'h200,   32'd0,     32'd4,     5'd2, 5'd9, 5'd9,  4'd0, 1'b1, 4'b1101, 1'b0, 1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,       1'b0, 5'b11101, 4'd0, 5'd9,  32'h124, 32'h200,   32'd4,    32'd0};

        // Reset with random ID traffic
        rst = 1'b1;
        set_id(1'b1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
               5'($urandom), 4'($urandom), 1'($urandom), 4'b1111, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk_bubble("reset");
            chk("reset.hold", {31'd0, hold_id}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single-cycle loads
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_id(vecs[i].valid, vecs[i].pc, vecs[i].rs_data, vecs[i].rt_data, vecs[i].imm,
                   vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].aluop, vecs[i].alusrc,
                   vecs[i].ctl, vecs[i].flush);
            set_fwd(vecs[i].exwr, vecs[i].exrd, vecs[i].exres,
                    vecs[i].mwwr, vecs[i].mwrd, vecs[i].mwdata);
            #1;
            chk($sformatf("v%0d.hold", i), {31'd0, hold_id}, {31'd0, vecs[i].e_hold});
            @(posedge clk); #1;
            chk($sformatf("v%0d.ctl", i),
                {27'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
                {27'd0, vecs[i].e_ctl});
            chk($sformatf("v%0d.aluop", i), {28'd0, ex_aluop}, {28'd0, vecs[i].e_aluop});
            chk($sformatf("v%0d.rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].e_rd});
            chk($sformatf("v%0d.pc", i), ex_pc, vecs[i].e_pc);
            chk($sformatf("v%0d.alu_a", i), alu_a, vecs[i].e_a);
            chk($sformatf("v%0d.alu_b", i), alu_b, vecs[i].e_b);
            chk($sformatf("v%0d.store", i), ex_store_data, vecs[i].e_st);
        end

        // Load-use: lw $9 now in EX, add reads $9
        @(negedge clk);
        set_id(1'b1, 32'h128, 32'd1, 32'd2, 32'd0, 5'd9, 5'd2, 5'd4, 4'd0, 1'b0, 4'b1000, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("lu.hold", {31'd0, hold_id}, 32'd1);
        @(posedge clk); #1;
        chk_bubble("lu.bubble");
        chk("lu.hold_after", {31'd0, hold_id}, 32'd0);
        @(negedge clk);
        set_fwd(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("lu.reload_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu.reload_rd", {27'd0, ex_rd}, 32'd4);
        chk("lu.reload_a", alu_a, 32'h77);
        chk("lu.reload_b", alu_b, 32'd2);

        // A load to $0 never stalls
        @(negedge clk);
        set_id(1'b1, 32'h12c, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b1, 4'b1101, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        set_id(1'b1, 32'h130, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd5, 4'd0, 1'b0, 4'b1000, 1'b0);
        #1;
        chk("zero_rd.hold", {31'd0, hold_id}, 32'd0);

        // Flush coinciding with load-use yields a single bubble
        @(negedge clk);
        set_id(1'b1, 32'h134, 32'd0, 32'd0, 32'd4, 5'd1, 5'd9, 5'd9, 4'd0, 1'b1, 4'b1101, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_id(1'b1, 32'h138, 32'd1, 32'd2, 32'd0, 5'd5, 5'd9, 5'd7, 4'd0, 1'b0, 4'b1000, 1'b1);
        #1;
        chk("fl.hold", {31'd0, hold_id}, 32'd1);
        @(posedge clk); #1;
        chk_bubble("fl.bubble");
        @(negedge clk);
        set_id(1'b1, 32'h200, 32'd1, 32'd2, 32'd0, 5'd5, 5'd6, 5'd7, 4'd3, 1'b0, 4'b1000, 1'b0);
        #1;
        chk("fl.next_hold", {31'd0, hold_id}, 32'd0);
        @(posedge clk); #1;
        chk("fl.next_valid", {31'd0, ex_valid}, 32'd1);
        chk("fl.next_aluop", {28'd0, ex_aluop}, 32'd3);
        chk("fl.next_pc", ex_pc, 32'h200);

        // Forwarding priority changes combinationally on the same stored instruction
        set_fwd(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        #1;
        chk("prio.exmem", alu_a, 32'h11);
        exmem_regwrite = 1'b0;
        #1;
        chk("prio.memwb", alu_a, 32'h22);

        // Reset mid-stream clears on the same edge
        @(negedge clk);
        rst = 1'b1;
        set_id(1'b1, 32'h300, 32'd1, 32'd2, 32'd3, 5'd1, 5'd2, 5'd3, 4'd2, 1'b0, 4'b1100, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk_bubble("midrst");
        chk("midrst.hold", {31'd0, hold_id}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
